wallace_mac_accumulator: RTL and testbench

Sequential multiply-accumulate stage that sits directly downstream of `wallace_tree_multiplier_4bit`. It accepts a stream of 4-bit operand pairs over a valid/ready handshake and multiplies each pair through an embedded `wallace_tree_multiplier_4bit` instance. It accumulates `N_TERMS` 8-bit products into one dot-product result, then presents that result on a valid/ready output port. Typical use is small dot-product and FIR-tap evaluation on top of the existing multiplier.

---
 rtl/wallace_mac_pkg.sv | 17 +
 rtl/wallace_tree_multiplier_4bit.sv | 28 ++
 rtl/wallace_mac_accumulator.sv | 93 +++++++++
 tb/tb_wallace_mac_accumulator.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/wallace_mac_pkg.sv
// rtl/wallace_mac_pkg.sv - shared types, widths and sizing helpers for the MAC stage
package wallace_mac_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } mac_state_t;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  // Counters must be able to hold N_TERMS itself, not just N_TERMS-1.
  function automatic int cnt_width(input int n_terms);
    return $clog2(n_terms + 1);
  endfunction

endpackage

// File: rtl/wallace_tree_multiplier_4bit.sv
// rtl/wallace_tree_multiplier_4bit.sv - unsigned 4x4 multiplier, carry-save reduction then one final add
module wallace_tree_multiplier_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P
);

  logic [7:0] pp0, pp1, pp2, pp3;
  logic [7:0] s1, c1, s2, c2;
  logic [7:0] maj1, maj2;

  assign pp0 = {4'b0, A & {4{B[0]}}};
  assign pp1 = {3'b0, A & {4{B[1]}}, 1'b0};
  assign pp2 = {2'b0, A & {4{B[2]}}, 2'b0};
  assign pp3 = {1'b0, A & {4{B[3]}}, 3'b0};

  // Two 3:2 compressor layers; the dropped carry MSBs are always zero since P < 256.
  assign s1   = pp0 ^ pp1 ^ pp2;
  assign maj1 = (pp0 & pp1) | (pp0 & pp2) | (pp1 & pp2);
  assign c1   = {maj1[6:0], 1'b0};

  assign s2   = s1 ^ c1 ^ pp3;
  assign maj2 = (s1 & c1) | (s1 & pp3) | (c1 & pp3);
  assign c2   = {maj2[6:0], 1'b0};

  assign P = s2 + c2;

endmodule

// File: rtl/wallace_mac_accumulator.sv
// rtl/wallace_mac_accumulator.sv - streams 4-bit operand pairs, accumulates N_TERMS products per result
module wallace_mac_accumulator
  import wallace_mac_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int CW = cnt_width(N_TERMS);

  if (N_TERMS < 1 || ACC_W < 8) begin : g_param_check
    $error("wallace_mac_accumulator: need N_TERMS >= 1 and ACC_W >= 8");
  end

  mac_state_t        state;
  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     acc_cnt;
  logic [PROD_W-1:0] prod_w;
  logic [PROD_W-1:0] prod_r;
  logic              prod_v;
  logic [ACC_W-1:0]  acc;
  logic              ovf;
  logic [ACC_W:0]    sum;
  logic              xfer;

  wallace_tree_multiplier_4bit u_mult (
    .A (a),
    .B (b),
    .P (prod_w)
  );

  assign in_ready  = (state == RUN) && (issue_cnt < CW'(N_TERMS)) && !clear;
  assign xfer      = in_valid && in_ready;
  assign sum       = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_r};
  assign out_valid = (state == DONE);
  assign out_acc   = acc;
  assign out_ovf   = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      issue_cnt <= '0;
      acc_cnt   <= '0;
      prod_r    <= '0;
      prod_v    <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else if (clear) begin
      state     <= RUN;
      issue_cnt <= '0;
      acc_cnt   <= '0;
      prod_v    <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else begin
      prod_v <= xfer;
      if (xfer) begin
        prod_r    <= prod_w;
        issue_cnt <= issue_cnt + CW'(1);
      end
      // Every issued product has been folded in by the time DONE is reached,
      // so the accumulate and hand-off branches never fire together.
      if (prod_v) begin
        acc     <= sum[ACC_W-1:0];
        ovf     <= ovf | sum[ACC_W];
        acc_cnt <= acc_cnt + CW'(1);
        if (acc_cnt == CW'(N_TERMS - 1)) begin
          state <= DONE;
        end
      end
      if (state == DONE && out_ready) begin
        state     <= RUN;
        issue_cnt <= '0;
        acc_cnt   <= '0;
        acc       <= '0;
        ovf       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wallace_mac_accumulator.sv
// tb/tb_wallace_mac_accumulator.sv - randomized and directed bench with a group-level reference model
module tb_wallace_mac_accumulator;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  a = '0;
  logic [3:0]  b = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_acc;
  logic        in_ready9, out_valid9, out_ovf9;
  logic [8:0]  out_acc9;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference: products of a group, summed as plain integers.
  int m_issued, m_nacc, m_sum, m_pval;
  bit m_pend, m_done;

  always #5 clk = ~clk;

  wallace_mac_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf)
  );

  wallace_mac_accumulator #(.N_TERMS(4), .ACC_W(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready9),
    .a(a), .b(b), .out_valid(out_valid9), .out_ready(out_ready), .out_acc(out_acc9), .out_ovf(out_ovf9)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_issued = 0; m_nacc = 0; m_sum = 0; m_pval = 0; m_pend = 0; m_done = 0;
  endtask

  task automatic cycle(input bit v, input logic [3:0] aa, input logic [3:0] bb,
                       input bit ordy, input bit clr);
    bit exp_rdy, xfer;
    in_valid = v; a = aa; b = bb; out_ready = ordy; clear = clr;
    @(negedge clk);
    exp_rdy = !m_done && (m_issued < N) && !clr;
    check("in_ready",   32'(in_ready),   32'(exp_rdy));
    check("in_ready9",  32'(in_ready9),  32'(exp_rdy));
    check("out_valid",  32'(out_valid),  32'(m_done));
    check("out_valid9", 32'(out_valid9), 32'(m_done));
    check("out_acc",    32'(out_acc),    32'(m_sum % 65536));
    check("out_ovf",    32'(out_ovf),    32'(m_sum >= 65536));
    check("out_acc9",   32'(out_acc9),   32'(m_sum % 512));
    check("out_ovf9",   32'(out_ovf9),   32'(m_sum >= 512));
    if (clr) begin
      model_reset();
    end else begin
      xfer = v && exp_rdy;
      if (m_done && ordy) begin
        m_sum = 0; m_issued = 0; m_nacc = 0; m_done = 0;
      end
      if (m_pend) begin
        m_sum += m_pval;
        m_nacc++;
        if (m_nacc == N) m_done = 1;
      end
      m_pend = xfer;
      m_pval = int'(aa) * int'(bb);
      if (xfer) m_issued++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 8 && !m_done; i++) cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic consume();
    cycle(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
  endtask

  initial begin
    model_reset();
    #3;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_acc",   32'(out_acc),   32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic group
    cycle(1, 4'hE, 4'hA, 1, 0);
    cycle(1, 4'h2, 4'h3, 1, 0);
    cycle(1, 4'h5, 4'h3, 1, 0);
    cycle(1, 4'hF, 4'hF, 1, 0);
    wait_done("basic");
    check("basic_acc", 32'(out_acc), 32'd386);
    check("basic_ovf", 32'(out_ovf), 32'd0);
    consume();

    // Back-pressure then a (1,1) group
    cycle(1, 4'hE, 4'hA, 0, 0);
    cycle(1, 4'h2, 4'h3, 0, 0);
    cycle(1, 4'h5, 4'h3, 0, 0);
    cycle(1, 4'hF, 4'hF, 0, 0);
    wait_done("bp");
    for (int i = 0; i < 5; i++) cycle(1, 4'h9, 4'h9, 0, 0);
    check("bp_acc_held", 32'(out_acc), 32'd386);
    consume();
    for (int i = 0; i < 4; i++) cycle(1, 4'h1, 4'h1, 1, 0);
    wait_done("ones");
    check("ones_acc", 32'(out_acc), 32'd4);
    consume();

    // Overflow on the 9-bit accumulator
    for (int i = 0; i < 4; i++) cycle(1, 4'hF, 4'hF, 1, 0);
    wait_done("ovf");
    check("ovf_acc9", 32'(out_acc9), 32'h184);
    check("ovf_flag9", 32'(out_ovf9), 32'd1);
    check("ovf_acc16", 32'(out_acc), 32'd900);
    consume();
    for (int i = 0; i < 4; i++) cycle(1, 4'h0, 4'h0, 1, 0);
    wait_done("zero");
    check("zero_acc9", 32'(out_acc9), 32'd0);
    check("zero_ovf9", 32'(out_ovf9), 32'd0);
    consume();

    // Bubbles
    cycle(1, 4'h3, 4'h3, 1, 0);
    cycle(0, 4'h3, 4'h3, 1, 0);
    cycle(0, 4'h3, 4'h3, 1, 0);
    cycle(1, 4'h3, 4'h3, 1, 0);
    cycle(0, 4'h3, 4'h3, 1, 0);
    cycle(1, 4'h3, 4'h3, 1, 0);
    cycle(1, 4'h3, 4'h3, 0, 0);
    cycle(0, 4'h0, 4'h0, 0, 0);
    check("bubble_valid", 32'(out_valid), 32'd1);
    check("bubble_acc", 32'(out_acc), 32'd36);
    consume();

    // Clear mid-group
    cycle(1, 4'h7, 4'h7, 1, 0);
    cycle(1, 4'h7, 4'h7, 1, 0);
    cycle(1, 4'h5, 4'h5, 1, 1);
    for (int i = 0; i < 4; i++) cycle(1, 4'h1, 4'h2, 1, 0);
    wait_done("clr");
    check("clr_acc", 32'(out_acc), 32'd8);
    consume();

    // Asynchronous reset while holding a result
    cycle(1, 4'hE, 4'hA, 0, 0);
    cycle(1, 4'h2, 4'h3, 0, 0);
    cycle(1, 4'h5, 4'h3, 0, 0);
    cycle(1, 4'hF, 4'hF, 0, 0);
    wait_done("arst");
    check("arst_pre_acc", 32'(out_acc), 32'd386);
    in_valid = 1'b0; clear = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_acc",   32'(out_acc),   32'd0);
    check("arst_out_ovf",   32'(out_ovf),   32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) cycle(1, 4'h2, 4'h2, 1, 0);
    wait_done("post_rst");
    check("post_rst_acc", 32'(out_acc), 32'd16);
    consume();

    // Randomized traffic with occasional clears
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
